im_loader: RTL and testbench
============================

// Module: im_loader
// PURPOSE
//   Writer side of the instruction-memory interface. Accepts a byte stream over a valid/ready handshake.
//   Packs bytes big-endian into 32-bit words (first byte -> [31:24]).
//   Issues one-cycle word writes into IM's write port at byte addresses rebased on BASE_ADDR.
//   Loads either the main program region (word 0 up) or the exception-handler region (word HANDLER_FIRST up).
//   Sits between the debug/boot byte source and IM; the CPU core is held off while busy=1.
// PARAMETERS
//   BASE_ADDR      32'h0000_3000  byte address of IM word 0
//   DEPTH_WORDS    4096           IM capacity in words
//   HANDLER_FIRST  1120           first word index of handler region (byte addr 32'h0000_4180)
//   HANDLER_LAST   2047           last word index of handler region
// PORTS
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous, active-low reset
//   start       in   1   pulse: begin a load session (ignored while busy=1)
//   region      in   1   sampled with start: 0=main [0..DEPTH_WORDS-1], 1=handler [HANDLER_FIRST..HANDLER_LAST]
//   byte_valid  in   1   source has a byte
//   byte_data   in   8   byte value
//   byte_last   in   1   qualifies byte_data as final byte of session
//   byte_ready  out  1   loader accepts byte this cycle
//   we          out  1   IM write strobe, one cycle per word
//   waddr       out  32  IM byte address = BASE_ADDR + idx*4
//   wdata       out  32  packed word
//   busy        out  1   session in progress
//   done        out  1   one-cycle pulse at session end
//   err         out  1   sticky until next start: region overflow
//   word_count  out  13  words written this session
// BEHAVIOUR
//   Reset (reset==0 at posedge): state=IDLE; all outputs 0; packer cleared.
//   Reset mid-session aborts with no further writes and no done pulse.
//   FSM states:
//     IDLE  -> (start) CLEAR if IM_LOADER_CLEAR_EN, else LOAD.
//              idx <= region ? HANDLER_FIRST : 0; err, word_count <= 0.
//     LOAD  -> byte_ready=1. Byte accepted iff byte_valid&&byte_ready; byte k of word goes to bits [31-8k -: 8].
//              4th byte accepted, or byte_last accepted: next cycle we=1, waddr/wdata registered, idx++, word_count++.
//              Partial word on byte_last: unfilled low bytes are 0.
//              byte_last -> DONE after that write.
//     DONE  -> done=1 for one cycle, busy=0 -> IDLE.
//   Write latency: we asserted exactly 1 cycle after the completing byte handshake.
//   Back-to-back bytes sustain 1 byte/cycle; byte_ready is not dropped during a write.
//   Overflow: a word completing with idx > limit (DEPTH_WORDS-1 or HANDLER_LAST):
//     no write; err=1; byte_ready=0; -> DONE.
//     Remaining source bytes are not consumed.
//   byte_last with 0 bytes pending is impossible (last is always on an accepted byte).
//   start while busy is ignored; start and byte_valid in the same IDLE cycle: byte not accepted.
//   waddr arithmetic is 32-bit unsigned; idx is 12 bits; word_count saturates never (max 4096 fits 13 bits).
// CONFIGURATION
//   IM_LOADER_CLEAR_EN defined:
//     CLEAR state writes 32'h0 to every word of the selected region, one per cycle, byte_ready=0.
//     Then idx is reset to the region start and FSM enters LOAD. word_count excludes clear writes.
//   IM_LOADER_CLEAR_EN undefined: no CLEAR state; unloaded words keep prior contents.
// STRUCTURE
//   Shared header mips_mem_defs: IM_BASE_ADDR, IM_DEPTH_WORDS, IM_HANDLER_FIRST, IM_HANDLER_LAST,
//     state encodings LDR_IDLE/LDR_CLEAR/LDR_LOAD/LDR_DONE.
//   One sub-module: im_word_packer (byte lane counter 0..3, shift/pack, flush-on-last, word_ready out).
// TESTING
//   1. region=0, bytes 24 01 00 05 + 00 00 00 0C (last on final byte)
//      -> we at 32'h3000=32'h24010005, then 32'h3004=32'h0000000C; done; word_count=2.
//   2. region=1, bytes AA BB CC DD
//      -> we waddr=32'h4180 wdata=32'hAABBCCDD.
//   3. region=0, 6 bytes, last on 6th -> second word 32'hXXYY0000 at 32'h3004; word_count=2.
//   4. region=1, 929 words streamed -> 928 writes (last at 32'h4FFC); err=1; 929th not written; byte_ready=0.
//   5. reset low after 2 bytes of a word -> next cycle busy=0, we=0; new start writes from 32'h3000.
//   6. IM_LOADER_CLEAR_EN, region=1: 928 zero writes 32'h4180..32'h4FFC precede first data write; byte_ready=0 throughout.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: IM geometry,
// FSM state encodings and address helpers.
package im_loader_pkg;

  localparam logic [31:0] IM_BASE_ADDR     = 32'h0000_3000;
  localparam int unsigned IM_DEPTH_WORDS   = 4096;
  localparam int unsigned IM_HANDLER_FIRST = 1120;
  localparam int unsigned IM_HANDLER_LAST  = 2047;

  localparam int unsigned IDX_W = 12;
  localparam int unsigned WC_W  = 13;

  typedef enum logic [1:0] {
    LDR_IDLE  = 2'd0,
    LDR_CLEAR = 2'd1,
    LDR_LOAD  = 2'd2,
    LDR_DONE  = 2'd3
  } ldr_state_e;

  // Byte address of word idx, 32-bit unsigned wrap-around arithmetic.
  function automatic logic [31:0] idx_to_addr(input logic [31:0] base,
                                              input logic [IDX_W-1:0] idx);
    return base + {18'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input and IM write-port bundle of the loader.
// master: the loader itself; slave: byte source / IM side.
interface im_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport master (
    input  byte_valid, byte_data, byte_last,
    output byte_ready, we, waddr, wdata
  );

  modport slave (
    output byte_valid, byte_data, byte_last,
    input  byte_ready, we, waddr, wdata
  );
endinterface

// File: rtl/im_word_packer.sv
// Big-endian byte-to-word packer. Byte lane 0 lands in [31:24].
// word/word_ready present the completed word in the same cycle as the
// completing byte (4th byte or a byte flagged last); unfilled lanes are 0.
module im_word_packer
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_fire,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] acc_q,  acc_d;

  // Merge the incoming byte into its lane to form the candidate word.
  always_comb begin
    word = acc_q;
    case (lane_q)
      2'd0:    word[31:24] = byte_data;
      2'd1:    word[23:16] = byte_data;
      2'd2:    word[15:8]  = byte_data;
      2'd3:    word[7:0]   = byte_data;
      default: word        = acc_q;
    endcase
    word_ready = byte_fire && ((lane_q == 2'd3) || byte_last);
  end

  // Advance lane/accumulator; restart empty after a flush or clear.
  always_comb begin
    lane_d = lane_q;
    acc_d  = acc_q;
    if (clr || word_ready) begin
      lane_d = 2'd0;
      acc_d  = 32'h0000_0000;
    end else if (byte_fire) begin
      lane_d = lane_q + 2'd1;
      acc_d  = word;
    end else begin
      lane_d = lane_q;
      acc_d  = acc_q;
    end
  end

  // Packer state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lane_q <= 2'd0;
      acc_q  <= 32'h0000_0000;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: accepts a byte stream, packs big-endian
// words and writes them into IM starting at the main or handler region.
// Optional feature: define IM_LOADER_CLEAR_EN to zero the selected
// region before loading.
module im_loader
  import im_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = IM_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS   = IM_DEPTH_WORDS,
  parameter int unsigned HANDLER_FIRST = IM_HANDLER_FIRST,
  parameter int unsigned HANDLER_LAST  = IM_HANDLER_LAST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            region,
  im_loader_if.master     bus,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [WC_W-1:0] word_count
);

  localparam logic [IDX_W-1:0] MAIN_FIRST_IDX = 12'd0;
  localparam logic [IDX_W-1:0] MAIN_LAST_IDX  = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [IDX_W-1:0] HDL_FIRST_IDX  = IDX_W'(HANDLER_FIRST);
  localparam logic [IDX_W-1:0] HDL_LAST_IDX   = IDX_W'(HANDLER_LAST);

  ldr_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  // Set once the region's last word has been written; any further word
  // completion is an overflow (idx has gone past the limit).
  logic             past_end_q, past_end_d;
  logic             region_q, region_d;
  logic             we_q, we_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             byte_ready_q, byte_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WC_W-1:0]  wc_q, wc_d;

  logic             byte_fire_s;
  logic             last_fire_s;
  logic             pack_clr_s;
  logic [31:0]      pack_word_s;
  logic             pack_ready_s;
  logic [IDX_W-1:0] first_idx_s;
  logic [IDX_W-1:0] limit_idx_s;

  assign byte_fire_s = bus.byte_valid && byte_ready_q;
  assign last_fire_s = byte_fire_s && bus.byte_last;

  im_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr        (pack_clr_s),
    .byte_fire  (byte_fire_s),
    .byte_data  (bus.byte_data),
    .byte_last  (bus.byte_last),
    .word       (pack_word_s),
    .word_ready (pack_ready_s)
  );

  // Region bounds of the session in progress.
  always_comb begin
    if (region_q) begin
      first_idx_s = HDL_FIRST_IDX;
      limit_idx_s = HDL_LAST_IDX;
    end else begin
      first_idx_s = MAIN_FIRST_IDX;
      limit_idx_s = MAIN_LAST_IDX;
    end
  end

  // Next-state and next-output logic of the loader FSM.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    past_end_d   = past_end_q;
    region_d     = region_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    byte_ready_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    wc_d         = wc_q;
    pack_clr_s   = 1'b0;

    case (state_q)
      LDR_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          region_d   = region;
          idx_d      = region ? HDL_FIRST_IDX : MAIN_FIRST_IDX;
          past_end_d = 1'b0;
          err_d      = 1'b0;
          wc_d       = 13'd0;
          busy_d     = 1'b1;
          pack_clr_s = 1'b1;
`ifdef IM_LOADER_CLEAR_EN
          state_d      = LDR_CLEAR;
          byte_ready_d = 1'b0;
`else
          state_d      = LDR_LOAD;
          byte_ready_d = 1'b1;
`endif
        end else begin
          state_d = LDR_IDLE;
        end
      end

      LDR_CLEAR: begin
`ifdef IM_LOADER_CLEAR_EN
        we_d    = 1'b1;
        waddr_d = idx_to_addr(BASE_ADDR, idx_q);
        wdata_d = 32'h0000_0000;
        if (idx_q == limit_idx_s) begin
          // Ready rises one cycle into LOAD so no byte overlaps a clear write.
          idx_d   = first_idx_s;
          state_d = LDR_LOAD;
        end else begin
          idx_d   = idx_q + 12'd1;
          state_d = LDR_CLEAR;
        end
`else
        state_d = LDR_IDLE;
        busy_d  = 1'b0;
`endif
      end

      LDR_LOAD: begin
        byte_ready_d = 1'b1;
        if (pack_ready_s) begin
          if (past_end_q) begin
            // Overflow: drop the word and stop consuming the source.
            err_d        = 1'b1;
            byte_ready_d = 1'b0;
            pack_clr_s   = 1'b1;
            state_d      = LDR_DONE;
            done_d       = 1'b1;
            busy_d       = 1'b0;
          end else begin
            we_d    = 1'b1;
            waddr_d = idx_to_addr(BASE_ADDR, idx_q);
            wdata_d = pack_word_s;
            wc_d    = wc_q + 13'd1;
            if (idx_q == limit_idx_s) begin
              past_end_d = 1'b1;
            end else begin
              idx_d = idx_q + 12'd1;
            end
            if (last_fire_s) begin
              byte_ready_d = 1'b0;
              state_d      = LDR_DONE;
              done_d       = 1'b1;
              busy_d       = 1'b0;
            end else begin
              state_d = LDR_LOAD;
            end
          end
        end else begin
          state_d = LDR_LOAD;
        end
      end

      LDR_DONE: begin
        state_d = LDR_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = LDR_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset aborts a session.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= LDR_IDLE;
      idx_q        <= 12'd0;
      past_end_q   <= 1'b0;
      region_q     <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wc_q         <= 13'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      past_end_q   <= past_end_d;
      region_q     <= region_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      wc_q         <= wc_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign word_count     = wc_q;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: stimulus pushes expected IM writes,
// a negedge monitor pops and compares each write it sees.
module tb_im_loader;
  import im_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        region = 1'b0;
  logic        busy, done, err;
  logic [12:0] word_count;

  im_loader_if bus_if ();

  im_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .region     (region),
    .bus        (bus_if.master),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          at;   // expected cycle of the write, -1 = do not check
  } wr_t;

  wr_t sb_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every IM write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus_if.we !== 1'b0) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got we=%b addr %h data %h, expected no write",
                 bus_if.we, bus_if.waddr, bus_if.wdata);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("waddr", {32'd0, bus_if.waddr}, {32'd0, e.addr});
        check("wdata", {32'd0, bus_if.wdata}, {32'd0, e.data});
        if (e.at >= 0) check("we_latency", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic src_idle();
    bus_if.byte_valid = 1'b0;
    bus_if.byte_last  = 1'b0;
    bus_if.byte_data  = 8'h00;
  endtask

  // Present a byte until accepted or the budget runs out; returns at edge+1.
  task automatic send_byte(input logic [7:0] d, input logic last,
                           input int budget, output logic ok);
    logic r;
    bus_if.byte_valid = 1'b1;
    bus_if.byte_data  = d;
    bus_if.byte_last  = last;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      r = bus_if.byte_ready;
      @(posedge clk);
      #1;
      ok = r;
    end
  endtask

  task automatic put(input logic [7:0] d, input logic last, input logic wr,
                     input logic [31:0] addr, input logic [31:0] data);
    logic ok;
    send_byte(d, last, 6000, ok);
    check("byte_accept", {63'd0, ok}, 64'd1);
    if (ok && wr) sb_q.push_back('{addr: addr, data: data, at: int'(cyc)});
  endtask

  // Pulse start for one cycle; optionally offer a byte in the same cycle.
  task automatic do_start(input logic rgn, input logic with_valid);
    start  = 1'b1;
    region = rgn;
    if (with_valid) begin
      bus_if.byte_valid = 1'b1;
      bus_if.byte_data  = 8'hEE;
      bus_if.byte_last  = 1'b1;
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    region = 1'b0;
    src_idle();
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("err_cleared_on_start", {63'd0, err}, 64'd0);
`ifdef IM_LOADER_CLEAR_EN
    begin
      int first, last_i;
      first  = rgn ? 1120 : 0;
      last_i = rgn ? 2047 : 4095;
      for (int i = first; i <= last_i; i++)
        sb_q.push_back('{addr: 32'h0000_3000 + 32'(i) * 32'd4, data: 32'h0, at: -1});
    end
`endif
  endtask

  task automatic wait_done(input string name, input int exp_wc, input logic exp_err);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 6000 && !got; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        check({name, "_word_count"}, 64'(word_count), 64'(exp_wc));
        check({name, "_err"}, {63'd0, err}, {63'd0, exp_err});
        check({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
      end
    end
    check({name, "_done_seen"}, {63'd0, got}, 64'd1);
    @(posedge clk);
    #1;
    check({name, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    check({name, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    src_idle();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state",
          {busy, done, err, bus_if.we, bus_if.byte_ready, word_count, bus_if.waddr[15:0]},
          64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: two full words in main region; a start mid-session is ignored
    do_start(1'b0, 1'b0);
    put(8'h24, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h01, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h05, 1'b0, 1'b1, 32'h0000_3000, 32'h2401_0005);
    start = 1'b1;
    region = 1'b1;
    put(8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    start = 1'b0;
    region = 1'b0;
    put(8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h0C, 1'b1, 1'b1, 32'h0000_3004, 32'h0000_000C);
    src_idle();
    wait_done("t1", 2, 1'b0);

    // 2: handler region; byte offered with start must not be taken
    do_start(1'b1, 1'b1);
    put(8'hAA, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'hBB, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'hCC, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'hDD, 1'b1, 1'b1, 32'h0000_4180, 32'hAABB_CCDD);
    src_idle();
    wait_done("t2", 1, 1'b0);

    // 3: partial final word is zero-filled
    do_start(1'b0, 1'b0);
    put(8'h11, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h22, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h33, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h44, 1'b0, 1'b1, 32'h0000_3000, 32'h1122_3344);
    put(8'h55, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h66, 1'b1, 1'b1, 32'h0000_3004, 32'h5566_0000);
    src_idle();
    wait_done("t3", 2, 1'b0);

    // 4: handler overflow after 928 words
    do_start(1'b1, 1'b0);
    for (int i = 0; i < 928; i++) begin
      logic [15:0] iv;
      iv = 16'(i);
      put(8'hC0, 1'b0, 1'b0, 32'h0, 32'h0);
      put(8'hDE, 1'b0, 1'b0, 32'h0, 32'h0);
      put(iv[15:8], 1'b0, 1'b0, 32'h0, 32'h0);
      put(iv[7:0], 1'b0, 1'b1, 32'h0000_4180 + 32'(i) * 32'd4, {16'hC0DE, iv});
    end
    put(8'h5A, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h5A, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h5A, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h5A, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_done("t4", 928, 1'b1);
    send_byte(8'h77, 1'b0, 5, ok);
    check("overflow_not_consumed", {63'd0, ok}, 64'd0);
    src_idle();
    check("err_sticky", {63'd0, err}, 64'd1);

    // 5: reset mid-word aborts, new session restarts at word 0
    do_start(1'b0, 1'b0);
    put(8'hF1, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'hF2, 1'b0, 1'b0, 32'h0, 32'h0);
    src_idle();
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_abort", {61'd0, busy, bus_if.we, bus_if.byte_ready}, 64'd0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_abort_no_done", {63'd0, done}, 64'd0);
    do_start(1'b0, 1'b0);
    put(8'h01, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h02, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h03, 1'b0, 1'b0, 32'h0, 32'h0);
    put(8'h04, 1'b1, 1'b1, 32'h0000_3000, 32'h0102_0304);
    src_idle();
    wait_done("t5", 1, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
